// File: rtl/swbox_cfg_loader_if.sv
// Route-word stream between a configuration source (master) and the
// switch-box loader (slave).
// Optional build macro: SWBOX_CFG_PARITY_EN widens cfg_data to 7 bits
// (bit 6 carries odd parity over bits [6:0]).
//
// Handshake: a word transfers on every rising clk edge where cfg_valid and
// cfg_ready are both high. The master keeps cfg_data stable while cfg_valid
// is high and the word has not yet transferred. The slave may raise or drop
// cfg_ready at any time, and the master never waits on cfg_ready before
// raising cfg_valid.
interface swbox_cfg_loader_if;
`ifdef SWBOX_CFG_PARITY_EN
    localparam int DATA_W = 7;
`else
    localparam int DATA_W = 6;
`endif

    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/swbox_cfg_loader.sv
// Configuration loader for the 5x4 switch-box routing matrix.
//
// The loader collects 18 six-bit route words into shadow registers. It
// checks them one pin per cycle, then copies all of them to cfg_bus in a
// single cycle, so the matrix never sees a half-written configuration.
//
// Optional build macro: SWBOX_CFG_PARITY_EN. When it is defined, every word
// is parity-checked as it is accepted.
//
// Route word: [5:3] = source index, [2:0] = source side.
// Pin map:
//   0-4   top,    side 1
//   5-9   bottom, side 3
//   10-13 left,   side 4
//   14-17 right,  side 2
// Side 0 means undriven.
module swbox_cfg_loader #(
    parameter int NPINS  = 18,
    parameter int WORD_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clear,
    swbox_cfg_loader_if.slave       cfg,
    output logic [NPINS*WORD_W-1:0] cfg_bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic [4:0]              err_pin,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic [4:0] LAST_PIN = 5'(NPINS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [4:0]        cnt_q;
    logic [WORD_W-1:0] shadow_q [NPINS];
    logic              done_pend_q;

    logic              accept;
    logic [WORD_W-1:0] word_in;
    logic              par_bad;
    logic [WORD_W-1:0] chk_word;
    logic [2:0]        chk_side;
    logic [2:0]        chk_idx;
    logic [2:0]        own_side;
    logic [4:0]        own_pos;
    logic              range_bad;
    logic              self_bad;

    assign cfg.cfg_ready = (state_q == S_LOAD);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign word_in       = cfg.cfg_data[WORD_W-1:0];

`ifdef SWBOX_CFG_PARITY_EN
    // A correct word has an odd number of ones across all seven bits.
    assign par_bad = ~(^cfg.cfg_data);
`else
    assign par_bad = 1'b0;
`endif

    assign busy      = (state_q == S_LOAD) || (state_q == S_CHECK) || (state_q == S_COMMIT);
    assign err       = (state_q == S_ERR);
    assign state_dbg = state_q;

    // Select the word being checked. A pin number that is out of range reads as undriven.
    always_comb begin
        chk_word = '0;
        if (cnt_q <= LAST_PIN) begin
            chk_word = shadow_q[cnt_q];
        end
    end

    assign chk_side = chk_word[2:0];
    assign chk_idx  = chk_word[5:3];

    // Work out which side the pin under check sits on, and its position along that side.
    always_comb begin
        own_side = 3'd1;
        own_pos  = cnt_q;
        if (cnt_q < 5'd5) begin
            own_side = 3'd1;
            own_pos  = cnt_q;
        end else if (cnt_q < 5'd10) begin
            own_side = 3'd3;
            own_pos  = cnt_q - 5'd5;
        end else if (cnt_q < 5'd14) begin
            own_side = 3'd4;
            own_pos  = cnt_q - 5'd10;
        end else begin
            own_side = 3'd2;
            own_pos  = cnt_q - 5'd14;
        end
    end

    // Legality: the side code must exist, and the index must fit the source side's pin count.
    always_comb begin
        range_bad = 1'b0;
        case (chk_side)
            3'd0:       range_bad = 1'b0;
            3'd1, 3'd3: range_bad = (chk_idx > 3'd4);
            3'd2, 3'd4: range_bad = (chk_idx > 3'd3);
            default:    range_bad = 1'b1;
        endcase
        self_bad = (chk_side != 3'd0) && (chk_side == own_side) && ({2'b00, chk_idx} == own_pos);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (accept) begin
                    if (par_bad)                 state_d = S_ERR;
                    else if (cnt_q == LAST_PIN)  state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (range_bad || self_bad)   state_d = S_ERR;
                else if (cnt_q == LAST_PIN)  state_d = S_COMMIT;
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word counter, shadow registers and error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            err_code <= '0;
            err_pin  <= '0;
            for (int i = 0; i < NPINS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        cnt_q    <= '0;
                        err_code <= '0;
                        err_pin  <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        shadow_q[cnt_q] <= word_in;
                        if (par_bad) begin
                            err_code <= 2'd3;
                            err_pin  <= cnt_q;
                        end else if (cnt_q == LAST_PIN) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (range_bad) begin
                        err_code <= 2'd1;
                        err_pin  <= cnt_q;
                    end else if (self_bad) begin
                        err_code <= 2'd2;
                        err_pin  <= cnt_q;
                    end else if (cnt_q == LAST_PIN) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Active config. It changes only on an atomic commit, or on clear while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_bus <= '0;
        end else if (state_q == S_COMMIT) begin
            for (int i = 0; i < NPINS; i++) begin
                cfg_bus[WORD_W*i +: WORD_W] <= shadow_q[i];
            end
        end else if ((state_q == S_IDLE) && clear && !start) begin
            cfg_bus <= '0;
        end
    end

    // Delay done so it pulses the cycle after cfg_bus takes the new config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_pend_q <= 1'b0;
            done        <= 1'b0;
        end else begin
            done_pend_q <= (state_q == S_COMMIT);
            done        <= done_pend_q;
        end
    end

endmodule
